eeprom_i2c_slave: RTL and testbench
===================================

// Module: eeprom_i2c_slave
// PURPOSE
// Synthesizable I2C responder modelling a 24C16-style 2 KB serial EEPROM: the far end of the
// EEPROM_WR master bus. Oversamples SCL/SDA on CLK, decodes start/stop, ACKs control/address/data
// bytes, writes its internal memory, and shifts read data out MSB first. Used as the bench/FPGA
// target for master bring-up. CLK must run at >=8x the SCL frequency.
// PARAMETERS
// DEV_ID     4'b1010  device type code, compared against control byte [7:4]
// ADDR_W     11       word address width; memory depth = 2**ADDR_W bytes
// PORTS
// CLK        in     1   system clock; all logic on posedge
// RESET      in     1   synchronous, active-high
// SCL        in     1   I2C serial clock from the master; asynchronous to CLK
// SDA        inout  1   I2C data; open-drain: driven 1'b0 or released to 1'bz, never driven 1
// BUSY       out    1   1 whenever state != IDLE
// WR_PULSE   out    1   one-CLK pulse per byte committed to memory
// WR_ADDR    out    11  address of the committed byte; valid while WR_PULSE=1
// WR_DATA    out    8   data of the committed byte; valid while WR_PULSE=1
// BEHAVIOUR
// - Reset: state=IDLE, SDA released (z), addr=0, BUSY=0, WR_PULSE=0, WR_ADDR=0, WR_DATA=0,
//   bit counter=0. Memory contents are not cleared. Reset mid-transfer releases SDA on the next CLK.
// - Input path: SCL and SDA each pass a 2-FF synchronizer plus a history FF. scl_rise/scl_fall are
//   derived from synced SCL. START = SDA 1->0 while SCL=1; STOP = SDA 0->1 while SCL=1.
// - START/STOP take priority over any SCL edge in the same CLK.
//   START from any state (incl. repeated start): goto CTRL, bitcnt=0, release SDA.
//   STOP from any state: goto IDLE, release SDA.
// - Receive bits are sampled on scl_rise, MSB first. SDA_OE changes only on scl_fall.
// - States:
//   IDLE: wait for START.
//   CTRL: shift 8 bits. If [7:4]==DEV_ID, set addr[10:8]=[3:1], rw=[0], goto CTRL_ACK;
//         otherwise leave SDA released (NACK) and goto IDLE.
//   CTRL_ACK: pull SDA low from the scl_fall after bit 0 until the next scl_fall.
//         rw=0 -> ADDR. rw=1 -> RDATA: load mem[addr] into the shift reg, drive bit7 on that same
//         scl_fall (low->0, high->release).
//   ADDR: shift 8 bits into addr[7:0] -> ADDR_ACK -> WDATA.
//   WDATA: shift 8 bits -> WDATA_ACK. On entry to the ACK: mem[addr]<=byte; WR_PULSE=1 for one CLK
//         with WR_ADDR=addr, WR_DATA=byte; then addr<=addr+1, wrapping 2**ADDR_W-1 -> 0.
//         After ACK return to WDATA; there is no page limit.
//   RDATA: shift the next bit out on each scl_fall. Release SDA on the scl_fall after bit 0
//         -> RACK.
//   RACK: sample SDA on scl_rise; addr<=addr+1 (wrapping) either way.
//         SDA=0 (ACK): load mem[addr+1], drive its bit7 on the next scl_fall, goto RDATA.
//         SDA=1 (NACK): keep SDA released, goto IDLE.
// - A partial byte (STOP or START before 8 bits) is discarded: no memory write, addr unchanged.
// - A random read uses the dummy write: CTRL(rw=0), ADDR, then repeated START and CTRL(rw=1).
//   The read returns mem at the address that was just loaded.
// - Memory: 2**ADDR_W x 8 register array, one write port, one read port.
// TESTING
// 1 Byte write: START,8'hA2,8'h34,8'h5A,STOP -> SDA low on all 3 ACK clocks; one WR_PULSE with
//   WR_ADDR=11'h134 and WR_DATA=8'h5A; BUSY=0 after STOP.
// 2 Random read: dummy write A2,34; repeated START; 8'hA3; master NACK; STOP -> SDA carries 8'h5A
//   MSB first, is released on the 9th clock, BUSY=0.
// 3 Sequential read wrap: preload 7FF=8'h11 and 000=8'h22; read from 11'h7FF with master ACK then
//   NACK -> bytes 8'h11, 8'h22 returned.
// 4 Multi-byte write wrap: write 8'hAA,8'hBB,8'hCC at 11'h7FE -> mem 7FE=AA, 7FF=BB, 000=CC;
//   3 WR_PULSEs.
// 5 Wrong ID: control byte 8'hB0 -> SDA stays z on the 9th clock; no WR_PULSE; IDLE.
// 6 Aborts: STOP after 4 data bits -> no write, IDLE. RESET while the slave drives SDA=0 in RDATA
//   -> SDA=z and BUSY=0 one CLK later.

Source files
------------

// File: rtl/eeprom_i2c_slave.sv
// I2C responder modelling a 24C16-style 2 KB serial EEPROM: byte/sequential write, random/sequential read.
// SCL/SDA are oversampled on CLK (CLK >= 8x SCL); SDA is open-drain, only ever pulled low or released.
module eeprom_i2c_slave #(
  parameter logic [3:0] DEV_ID = 4'b1010,
  parameter int         ADDR_W = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              BUSY,
  output logic              WR_PULSE,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA
);

  localparam int HI_W = ADDR_W - 8;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [3:0] {
    IDLE,
    CTRL,
    CTRL_ACK,
    ADDR,
    ADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } state_t;

  state_t            state_q;
  logic              scl_s1_q, scl_s2_q, scl_h_q;
  logic              sda_s1_q, sda_s2_q, sda_h_q;
  logic              sda_oe_q;
  logic              rw_q;
  logic              phase_q;
  logic [2:0]        bitcnt_q;
  logic [7:0]        shreg_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_pulse_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        mem_q [2**ADDR_W];

  logic              scl_rise, scl_fall, start_det, stop_det, byte_done;
  logic [7:0]        byte_d;
  logic [7:0]        mem_rd;
  logic [ADDR_W-1:0] addr_inc_d;

  assign scl_rise   = scl_s2_q & ~scl_h_q;
  assign scl_fall   = ~scl_s2_q & scl_h_q;
  assign start_det  = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det   = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign byte_d     = {shreg_q[6:0], sda_s2_q};
  assign byte_done  = scl_rise && (bitcnt_q == 3'd7);
  assign addr_inc_d = addr_q + ADDR_ONE;
  assign mem_rd     = mem_q[addr_q];

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign BUSY     = (state_q != IDLE);
  assign WR_PULSE = wr_pulse_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;

  // Memory is written from the registered commit strobe, one CLK after the pulse.
  always_ff @(posedge CLK) begin
    if (wr_pulse_q) begin
      mem_q[wr_addr_q] <= wr_data_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_h_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_h_q    <= 1'b1;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      bitcnt_q   <= 3'd0;
      shreg_q    <= 8'd0;
      addr_q     <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
    end else begin
      scl_s1_q   <= SCL;
      scl_s2_q   <= scl_s1_q;
      scl_h_q    <= scl_s2_q;
      sda_s1_q   <= SDA;
      sda_s2_q   <= sda_s1_q;
      sda_h_q    <= sda_s2_q;
      wr_pulse_q <= 1'b0;

      if (start_det) begin
        state_q  <= CTRL;
        bitcnt_q <= 3'd0;
        phase_q  <= 1'b0;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        bitcnt_q <= 3'd0;
        phase_q  <= 1'b0;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;

          CTRL, ADDR, WDATA: begin
            if (scl_rise) begin
              shreg_q  <= byte_d;
              bitcnt_q <= bitcnt_q + 3'd1;
            end
            if (byte_done) begin
              phase_q <= 1'b0;
              if (state_q == CTRL) begin
                if (byte_d[7:4] == DEV_ID) begin
                  addr_q[ADDR_W-1:8] <= byte_d[HI_W:1];
                  rw_q               <= byte_d[0];
                  state_q            <= CTRL_ACK;
                end else begin
                  state_q <= IDLE;
                end
              end else if (state_q == ADDR) begin
                addr_q[7:0] <= byte_d;
                state_q     <= ADDR_ACK;
              end else begin
                wr_pulse_q <= 1'b1;
                wr_addr_q  <= addr_q;
                wr_data_q  <= byte_d;
                addr_q     <= addr_inc_d;
                state_q    <= WDATA_ACK;
              end
            end
          end

          // ACK is held low from the fall after bit 0 to the fall ending the 9th clock.
          CTRL_ACK, ADDR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                phase_q  <= 1'b0;
                bitcnt_q <= 3'd0;
                if (state_q == CTRL_ACK && rw_q) begin
                  shreg_q  <= mem_rd;
                  sda_oe_q <= ~mem_rd[7];
                  state_q  <= RDATA;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == CTRL_ACK) ? ADDR : WDATA;
                end
              end
            end
          end

          RDATA: begin
            if (scl_fall) begin
              if (bitcnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                bitcnt_q <= 3'd0;
                phase_q  <= 1'b0;
                state_q  <= RACK;
              end else begin
                shreg_q  <= {shreg_q[6:0], 1'b0};
                sda_oe_q <= ~shreg_q[6];
                bitcnt_q <= bitcnt_q + 3'd1;
              end
            end
          end

          // phase_q=1 means the master ACKed and the next byte goes out on the coming fall.
          RACK: begin
            if (!phase_q) begin
              if (scl_rise) begin
                addr_q <= addr_inc_d;
                if (!sda_s2_q) begin
                  phase_q <= 1'b1;
                end else begin
                  state_q <= IDLE;
                end
              end
            end else if (scl_fall) begin
              shreg_q  <= mem_rd;
              sda_oe_q <= ~mem_rd[7];
              bitcnt_q <= 3'd0;
              phase_q  <= 1'b0;
              state_q  <= RDATA;
            end
          end

          default: begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Bench for eeprom_i2c_slave: bit-banged I2C master, array reference model, scoreboard queues
// for committed writes and returned read bytes.
module tb_eeprom_i2c_slave;

  localparam int Q = 40;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SCL = 1'b1;
  logic        m_low = 1'b0;
  wire         SDA;
  logic        BUSY;
  logic        WR_PULSE;
  logic [10:0] WR_ADDR;
  logic [7:0]  WR_DATA;

  assign SDA = m_low ? 1'b0 : 1'bz;
  pullup (SDA);

  eeprom_i2c_slave #(.DEV_ID(4'b1010), .ADDR_W(11)) dut (
    .CLK(CLK), .RESET(RESET), .SCL(SCL), .SDA(SDA),
    .BUSY(BUSY), .WR_PULSE(WR_PULSE), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem_m [2048];
  logic [18:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  obs_rd_q [$];
  logic [7:0]  wbuf [8];
  logic [18:0] e_wr;
  logic [7:0]  e_rd, o_rd;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: commits and read bytes are compared as they appear.
  always @(negedge CLK) begin
    if (WR_PULSE) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual=%0h/%0h required=none", WR_ADDR, WR_DATA);
      end else begin
        e_wr = exp_wr_q.pop_front();
        check("wr_addr", int'(WR_ADDR), int'(e_wr[18:8]));
        check("wr_data", int'(WR_DATA), int'(e_wr[7:0]));
      end
    end
    if (obs_rd_q.size() > 0) begin
      o_rd = obs_rd_q.pop_front();
      if (exp_rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=%0h required=none", o_rd);
      end else begin
        e_rd = exp_rd_q.pop_front();
        check("rd_byte", int'(o_rd), int'(e_rd));
      end
    end
  end

  task automatic wr_bit(input logic b);
    #Q m_low = ~b;
    #Q SCL = 1'b1;
    #(2*Q) SCL = 1'b0;
  endtask

  task automatic rd_bit(output logic b);
    #Q m_low = 1'b0;
    #Q SCL = 1'b1;
    #Q b = SDA;
    #Q SCL = 1'b0;
  endtask

  task automatic i2c_start();
    #Q m_low = 1'b0;
    #Q SCL = 1'b1;
    #Q m_low = 1'b1;
    #Q SCL = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q m_low = 1'b1;
    #Q SCL = 1'b1;
    #Q m_low = 1'b0;
    #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
    ack = ~a;
  endtask

  task automatic rd_byte(input logic ack);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    obs_rd_q.push_back(d);
    #Q m_low = ack;
    #Q SCL = 1'b1;
    #Q b = SDA;
    #Q SCL = 1'b0;
    if (!ack) check("rd_9th_released", int'(b), 1);
  endtask

  task automatic wait_idle(input string tag);
    repeat (6) @(negedge CLK);
    check({tag, "_busy"}, int'(BUSY), 0);
    check({tag, "_wr_drained"}, exp_wr_q.size(), 0);
    check({tag, "_rd_drained"}, exp_rd_q.size(), 0);
  endtask

  task automatic do_write(input logic [10:0] a, input int n);
    logic ack;
    logic [10:0] ai;
    i2c_start();
    wr_byte({4'hA, a[10:8], 1'b0}, ack);
    check("w_ctrl_ack", int'(ack), 1);
    wr_byte(a[7:0], ack);
    check("w_addr_ack", int'(ack), 1);
    for (int i = 0; i < n; i++) begin
      ai = a + 11'(i);
      mem_m[ai] = wbuf[i];
      exp_wr_q.push_back({ai, wbuf[i]});
      wr_byte(wbuf[i], ack);
      check("w_data_ack", int'(ack), 1);
    end
    i2c_stop();
    wait_idle("write");
  endtask

  task automatic do_read(input logic [10:0] a, input int n);
    logic ack;
    logic [10:0] ai;
    i2c_start();
    wr_byte({4'hA, a[10:8], 1'b0}, ack);
    check("r_ctrlw_ack", int'(ack), 1);
    wr_byte(a[7:0], ack);
    check("r_addr_ack", int'(ack), 1);
    i2c_start();
    wr_byte({4'hA, a[10:8], 1'b1}, ack);
    check("r_ctrlr_ack", int'(ack), 1);
    for (int i = 0; i < n; i++) begin
      ai = a + 11'(i);
      exp_rd_q.push_back(mem_m[ai]);
      rd_byte(i != n - 1);
    end
    i2c_stop();
    wait_idle("read");
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic b;
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_busy", int'(BUSY), 0);
    check("rst_wr_pulse", int'(WR_PULSE), 0);
    check("rst_wr_addr", int'(WR_ADDR), 0);
    check("rst_wr_data", int'(WR_DATA), 0);
    check("rst_sda", int'(SDA), 1);

    // Byte write, then random read of the same location.
    wbuf[0] = 8'h5A;
    do_write(11'h134, 1);
    do_read(11'h134, 1);

    // Sequential read across the top of memory.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(11'h7FF, 2);
    do_read(11'h7FF, 2);

    // Multi-byte write wrapping, read back.
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
    do_write(11'h7FE, 3);
    do_read(11'h7FE, 3);

    // Wrong device ID: NACK and back to IDLE.
    i2c_start();
    wr_byte(8'hB0, ack);
    check("wrong_id_ack", int'(ack), 0);
    check("wrong_id_busy", int'(BUSY), 0);
    i2c_stop();
    wait_idle("wrong_id");

    // STOP after 4 data bits: no write, address stays at 0x134 for a current-address read.
    i2c_start();
    wr_byte(8'hA2, ack);
    wr_byte(8'h34, ack);
    for (int i = 0; i < 4; i++) wr_bit(1'b1);
    i2c_stop();
    wait_idle("abort");
    i2c_start();
    wr_byte(8'hA3, ack);
    check("cur_ctrl_ack", int'(ack), 1);
    exp_rd_q.push_back(mem_m[11'h134]);
    rd_byte(1'b0);
    i2c_stop();
    wait_idle("cur_read");

    // RESET while the slave pulls SDA low for bit7 (0x5A has bit7=0).
    i2c_start();
    wr_byte(8'hA2, ack);
    wr_byte(8'h34, ack);
    i2c_start();
    wr_byte(8'hA3, ack);
    #60;
    check("rdata_sda_low", int'(SDA), 0);
    check("rdata_busy", int'(BUSY), 1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_mid_sda", int'(SDA), 1);
    check("rst_mid_busy", int'(BUSY), 0);
    RESET = 1'b0;
    i2c_stop();
    wait_idle("after_reset");

    // Randomized write / read-back windows.
    for (int it = 0; it < 8; it++) begin
      logic [10:0] a;
      int n, k, m;
      a = 11'($urandom_range(0, 2047));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      do_write(a, n);
      k = $urandom_range(0, n - 1);
      m = $urandom_range(1, n - k);
      do_read(a + 11'(k), m);
    end

    b = SDA;
    check("final_sda", int'(b), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
